// File: rtl/axis_frame_sched.sv
// axis_frame_sched: forwards a scheduled number of whole AXI-stream video frames, aligned to SOF.
// Optional macro FRAME_SCHED_STALL_CNT_EN adds the stall_cnt output (output back-pressure cycles).
module axis_frame_sched #(
    parameter int DW       = 24,
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080,
    parameter int FCNT_W   = 16
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [FCNT_W-1:0] num_frames,
    input  logic [DW-1:0]     s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tuser,
    input  logic              s_tlast,
    output logic [DW-1:0]     m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tuser,
    output logic              m_tlast,
    output logic              busy,
    output logic              done,
    output logic [FCNT_W-1:0] frame_cnt,
`ifdef FRAME_SCHED_STALL_CNT_EN
    output logic [31:0]       stall_cnt,
`endif
    output logic [2:0]        err_flags
);

    localparam int PX_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int LN_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_SOF = 2'd1;
    localparam logic [1:0] ST_PASS     = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [PX_W-1:0]   px;
    logic [LN_W-1:0]   ln;
    logic [FCNT_W-1:0] num_r;
    logic              stop_pend;

    logic stop_any;
    logic acc;
    logic fwd;
    logic in_pass;
    logic new_sof;
    logic px_last;
    logic ln_last;
    logic eol;
    logic frame_end;
    logic last_frame;

    always_comb begin
        s_tready = 1'b1;
        if (state == ST_WAIT_SOF || state == ST_PASS) begin
            s_tready = !m_tvalid || m_tready;
        end
    end

    assign stop_any  = stop | stop_pend;
    assign acc       = s_tvalid & s_tready;
    assign px_last   = (px == PX_W'(H_ACTIVE - 1));
    assign ln_last   = (ln == LN_W'(V_ACTIVE - 1));
    assign in_pass   = acc & (state == ST_PASS);
    // A stop racing a SOF in WAIT_SOF wins, so that SOF beat is dropped rather than forwarded.
    assign fwd       = (state == ST_PASS) | ((state == ST_WAIT_SOF) & s_tuser & !stop_any);
    assign new_sof   = in_pass & s_tuser & ((px != '0) | (ln != '0));
    assign eol       = in_pass & !new_sof & (s_tlast | px_last);
    assign frame_end = eol & ln_last;
    assign last_frame = ((num_r != '0) &&
                         ((FCNT_W+1)'(frame_cnt) + (FCNT_W+1)'(1) == (FCNT_W+1)'(num_r)))
                        || stop_any;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start) state_nxt = ST_WAIT_SOF;
            ST_WAIT_SOF: begin
                if (stop_any) state_nxt = ST_DONE;
                else if (acc && s_tuser) state_nxt = ST_PASS;
            end
            ST_PASS:     if (frame_end && last_frame) state_nxt = ST_DONE;
            ST_DONE:     if (!m_tvalid) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            m_tvalid  <= 1'b0;
            m_tdata   <= '0;
            m_tuser   <= 1'b0;
            m_tlast   <= 1'b0;
            frame_cnt <= '0;
            err_flags <= '0;
            px        <= '0;
            ln        <= '0;
            num_r     <= '0;
            stop_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == ST_WAIT_SOF) || (state_nxt == ST_PASS);
            done  <= (state == ST_DONE) && !m_tvalid;

            if (acc && fwd) begin
                m_tdata  <= s_tdata;
                m_tuser  <= s_tuser;
                m_tlast  <= s_tlast;
                m_tvalid <= 1'b1;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end

            if (state_nxt == ST_IDLE) begin
                stop_pend <= 1'b0;
            end else if (stop && state != ST_IDLE) begin
                stop_pend <= 1'b1;
            end

            if (state == ST_IDLE && start) begin
                num_r     <= num_frames;
                frame_cnt <= '0;
                err_flags <= '0;
            end

            if (acc && fwd && state == ST_WAIT_SOF) begin
                px <= PX_W'(1);
                ln <= '0;
            end else if (in_pass) begin
                if (new_sof) begin
                    err_flags[2] <= 1'b1;
                    px           <= PX_W'(1);
                    ln           <= '0;
                end else begin
                    if (s_tlast && !px_last) err_flags[0] <= 1'b1;
                    if (!s_tlast && px_last) err_flags[1] <= 1'b1;
                    // Real or forced end of line both advance the line and may close the frame.
                    if (eol) begin
                        px <= '0;
                        ln <= ln_last ? '0 : ln + LN_W'(1);
                    end else begin
                        px <= px + PX_W'(1);
                    end
                    if (frame_end && frame_cnt != '1) frame_cnt <= frame_cnt + FCNT_W'(1);
                end
            end
        end
    end

`ifdef FRAME_SCHED_STALL_CNT_EN
    always_ff @(posedge clk_in) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (state == ST_IDLE && start) begin
            stall_cnt <= '0;
        end else if (busy && m_tvalid && !m_tready && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
